vend_ctrl: RTL and testbench

Parametrised vending controller that accepts half-unit and one-unit coins, tracks credit in half-units, vends at a configurable price, and returns change or a full refund as serial half-unit pulses. It sits between the debounced coin/cancel inputs and the dispensing and coin-return actuators. It supports simultaneous coins, cancel/refund, multi-pulse change and coin rejection while busy.

---
 rtl/vend_ctrl.sv | 133 +++++++++++++
 tb/tb_vend_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/vend_ctrl.sv
// vend_ctrl: vending controller. It accepts half-unit and one-unit coins and
// tracks credit in half-units. When the credit reaches PRICE it vends one
// item. It pays any change, or a full refund on cancel, as a serial train of
// half-unit pulses. Coins presented while the controller is busy are
// rejected.
//
// Parameters
//   PRICE  item price in half-units (>= 2)
//   CNT_W  credit register width (2**CNT_W > PRICE+2)
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   pi_coin_half  one-cycle pulse, 0.5 coin inserted (value 1)
//   pi_coin_one   one-cycle pulse, 1.0 coin inserted (value 2)
//   pi_cancel     one-cycle pulse, refund request
//   po_cola       one-cycle dispense pulse
//   po_change     one pulse per half-unit returned
//   po_coin_rej   one-cycle pulse, coin(s) rejected while busy
//   po_busy       high while vending or paying out
//   po_credit     current credit in half-units
module vend_ctrl #(
  parameter int PRICE = 5,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pi_coin_half,
  input  logic             pi_coin_one,
  input  logic             pi_cancel,
  output logic             po_cola,
  output logic             po_change,
  output logic             po_coin_rej,
  output logic             po_busy,
  output logic [CNT_W-1:0] po_credit
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCUM  = 3'd1,
    S_VEND   = 3'd2,
    S_CHANGE = 3'd3,
    S_REFUND = 3'd4
  } state_t;

  localparam logic [CNT_W:0] LP_PRICE = (CNT_W+1)'(PRICE);

  state_t           r_state;
  logic [CNT_W-1:0] r_credit;
  logic             r_cola;
  logic             r_change;
  logic             r_rej;

  logic             w_busy;
  logic             w_coin;
  logic [CNT_W:0]   w_add;
  logic [CNT_W:0]   w_sum;

  // Busy covers the trailing cycle of the last cola/change pulse, because the
  // state has already returned to IDLE by then.
  assign w_busy = (r_state == S_VEND) || (r_state == S_CHANGE) ||
                  (r_state == S_REFUND) || r_cola || r_change;

  assign w_coin = pi_coin_half | pi_coin_one;
  // The sum is one bit wider than the credit, so PRICE-1+3 cannot wrap
  // before the compare.
  assign w_add  = (CNT_W+1)'({pi_coin_one, pi_coin_half});
  assign w_sum  = {1'b0, r_credit} + w_add;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_credit <= '0;
      r_cola   <= 1'b0;
      r_change <= 1'b0;
      r_rej    <= 1'b0;
    end else begin
      r_cola   <= 1'b0;
      r_change <= 1'b0;
      r_rej    <= w_busy & w_coin;

      case (r_state)
        S_IDLE, S_ACCUM: begin
          // During the trailing pulse cycle the state is already IDLE, but
          // coins and cancel must still be ignored there.
          if (!w_busy) begin
            if (w_sum >= LP_PRICE) begin
              r_state  <= S_VEND;
              r_credit <= CNT_W'(w_sum - LP_PRICE);
              r_cola   <= 1'b1;
            end else if (pi_cancel && (w_sum != '0)) begin
              r_state  <= S_REFUND;
              r_credit <= CNT_W'(w_sum);
            end else begin
              r_credit <= CNT_W'(w_sum);
              r_state  <= (w_sum != '0) ? S_ACCUM : S_IDLE;
            end
          end
        end

        S_VEND: begin
          if (r_credit == '0) begin
            r_state <= S_IDLE;
          end else begin
            r_change <= 1'b1;
            r_credit <= r_credit - 1'b1;
            r_state  <= (r_credit == CNT_W'(1)) ? S_IDLE : S_CHANGE;
          end
        end

        S_CHANGE, S_REFUND: begin
          r_change <= 1'b1;
          r_credit <= r_credit - 1'b1;
          if (r_credit == CNT_W'(1)) begin
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_state  <= S_IDLE;
          r_credit <= '0;
        end
      endcase
    end
  end

  assign po_cola     = r_cola;
  assign po_change   = r_change;
  assign po_coin_rej = r_rej;
  assign po_busy     = w_busy;
  assign po_credit   = r_credit;

endmodule

// File: tb/tb_vend_ctrl.sv
module tb_vend_ctrl;

  localparam int PRICE = 5;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             pi_coin_half;
  logic             pi_coin_one;
  logic             pi_cancel;
  logic             po_cola;
  logic             po_change;
  logic             po_coin_rej;
  logic             po_busy;
  logic [CNT_W-1:0] po_credit;

  int n_checks;
  int n_errors;

  vend_ctrl #(.PRICE(PRICE), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pi_coin_half (pi_coin_half),
    .pi_coin_one  (pi_coin_one),
    .pi_cancel    (pi_cancel),
    .po_cola      (po_cola),
    .po_change    (po_change),
    .po_coin_rej  (po_coin_rej),
    .po_busy      (po_busy),
    .po_credit    (po_credit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Outputs are sampled 1 ns after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check every output against its expected value.
  task automatic outs(input string tag, input int cola, input int chg,
                      input int rej, input int busy, input int credit);
    chk({tag, ".cola"},   int'(po_cola),     cola);
    chk({tag, ".change"}, int'(po_change),   chg);
    chk({tag, ".rej"},    int'(po_coin_rej), rej);
    chk({tag, ".busy"},   int'(po_busy),     busy);
    chk({tag, ".credit"}, int'(po_credit),   credit);
  endtask

  // Apply one cycle of inputs, then clear them.
  task automatic drive(input logic h, input logic o, input logic c);
    pi_coin_half = h;
    pi_coin_one  = o;
    pi_cancel    = c;
    tick();
    pi_coin_half = 1'b0;
    pi_coin_one  = 1'b0;
    pi_cancel    = 1'b0;
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    rst_n        = 1'b0;
    pi_coin_half = 1'b0;
    pi_coin_one  = 1'b0;
    pi_cancel    = 1'b0;
    tick();
    tick();
    outs("reset", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    tick();

    // 1: five half coins, two cycles apart
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      chk($sformatf("t1.credit%0d", i), int'(po_credit), i);
      tick();
    end
    drive(1'b1, 1'b0, 1'b0);
    outs("t1.vend", 1, 0, 0, 1, 0);
    tick();
    outs("t1.after", 0, 0, 0, 0, 0);
    tick();
    outs("t1.idle", 0, 0, 0, 0, 0);

    // 2: three one-unit coins, sum 6, one change pulse
    drive(1'b0, 1'b1, 1'b0);
    chk("t2.credit2", int'(po_credit), 2);
    drive(1'b0, 1'b1, 1'b0);
    chk("t2.credit4", int'(po_credit), 4);
    drive(1'b0, 1'b1, 1'b0);
    outs("t2.vend", 1, 0, 0, 1, 1);
    tick();
    outs("t2.chg", 0, 1, 0, 1, 0);
    tick();
    outs("t2.done", 0, 0, 0, 0, 0);

    // 3: half+one together twice
    drive(1'b1, 1'b1, 1'b0);
    outs("t3.credit3", 0, 0, 0, 0, 3);
    drive(1'b1, 1'b1, 1'b0);
    outs("t3.vend", 1, 0, 0, 1, 1);
    tick();
    outs("t3.chg", 0, 1, 0, 1, 0);
    tick();
    outs("t3.done", 0, 0, 0, 0, 0);

    // 4: credit 3 then cancel -> three refund pulses
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    chk("t4.credit3", int'(po_credit), 3);
    drive(1'b0, 1'b0, 1'b1);
    outs("t4.refund", 0, 0, 0, 1, 3);
    tick();
    outs("t4.p1", 0, 1, 0, 1, 2);
    tick();
    outs("t4.p2", 0, 1, 0, 1, 1);
    tick();
    outs("t4.p3", 0, 1, 0, 1, 0);
    tick();
    outs("t4.done", 0, 0, 0, 0, 0);
    drive(1'b0, 1'b0, 1'b1);
    outs("t4.cancel0", 0, 0, 0, 0, 0);
    tick();
    outs("t4.cancel0b", 0, 0, 0, 0, 0);

    // 5: credit 4, one coin + cancel on the same edge -> vend wins
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    chk("t5.credit4", int'(po_credit), 4);
    drive(1'b0, 1'b1, 1'b1);
    outs("t5.vend", 1, 0, 0, 1, 1);
    tick();
    outs("t5.chg", 0, 1, 0, 1, 0);
    drive(1'b1, 1'b0, 1'b0);
    outs("t5.rej", 0, 0, 1, 0, 0);
    tick();
    outs("t5.done", 0, 0, 0, 0, 0);

    // 6: reset during the second refund pulse
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    outs("t6.refund", 0, 0, 0, 1, 3);
    tick();
    outs("t6.p1", 0, 1, 0, 1, 2);
    tick();
    outs("t6.p2", 0, 1, 0, 1, 1);
    #2;
    rst_n = 1'b0;
    #1;
    outs("t6.rst", 0, 0, 0, 0, 0);
    tick();
    outs("t6.rsthold", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    tick();
    outs("t6.release", 0, 0, 0, 0, 0);
    drive(1'b1, 1'b0, 1'b0);
    outs("t6.half", 0, 0, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
